id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode (register-file read) and execute. It latches the two register-file operands, immediate, PC, register specifiers and control bits under a valid/ready handshake. It supports stall (backpressure), flush (bubble insertion) and a write-back snoop, so the operands it presents to execute are never stale with respect to the register file.

## Interface
- XLEN, 64, operand/PC/immediate width
- RAW, 5, register specifier width
- CW, 8, packed control width {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  kill held and incoming instruction
- id_pc, id_imm, ReadData1, ReadData2  in  XLEN  decode payload; ReadData1/2 come from the register file
- id_rs1, id_rs2, id_rd  in  RAW  specifiers
- id_ctrl  in  CW  control bits
- wb_RegWrite  in  1  write-back write enable
- wb_rd  in  RAW  write-back destination
- wb_data  in  XLEN  write-back data
- out_valid  out  1  execute payload valid
- out_ready  in  1  execute consumes this cycle
- ex_pc, ex_imm, ex_op1, ex_op2  out  XLEN  registered payload
- ex_rs1, ex_rs2, ex_rd  out  RAW  registered specifiers
- ex_ctrl  out  CW  registered control; all zero whenever out_valid=0
- bubble_count  out  32  cycles with out_valid=0 since reset

## Operation
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready, combinational, independent of in_valid.
- Accept = in_valid && in_ready && !flush.
  - On accept, load the payload. State becomes FULL.
  - Otherwise, if out_ready or EMPTY, state becomes EMPTY and ex_ctrl is zeroed.
  - Otherwise FULL holds.
- flush has priority over everything. On the next edge: out_valid=0, ex_ctrl=0, and the incoming instruction is dropped.
- Load bypass: if wb_RegWrite && wb_rd!=0 && wb_rd==id_rs1, load ex_op1 from wb_data instead of ReadData1. The same rule applies to rs2/op2.
- Hold snoop: while FULL and not advancing, if wb_RegWrite && wb_rd!=0 && wb_rd==ex_rs1, overwrite ex_op1 with wb_data. The same rule applies to ex_rs2/ex_op2.
- rd=0 never bypasses.
- bubble_count increments each cycle out_valid=0 and wraps at 2^32-1 → 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready is held high.
- Reset (asynchronous assert, synchronous-to-clk deassert is external):
  - out_valid=0
  - all ex_* = 0
  - bubble_count=0
  - in_ready=1 on the first cycle after deassert.
- Reset mid-operation discards the held instruction immediately; no partial state survives.
- Simultaneous advance and new accept: the new payload replaces the old at the same edge with no bubble.
- Simultaneous hold snoop and flush: flush wins; the payload is a don't-care but ex_ctrl=0.
- Bypass and snoop compare against wb_* sampled at the same edge. Write-back data is therefore visible to execute one cycle after its write edge.

## Configuration
- ID_EX_BYPASS_EN
  - Defined: load bypass and hold snoop are active as specified.
  - Undefined: ex_op1/ex_op2 load ReadData1/ReadData2 unmodified and the held payload is never modified. Hazards are then the hazard unit's responsibility (it must stall).

## Structure
- Shared package riscv_pkg holds:
  - XLEN and RAW
  - ctrl_t packed struct, with bit order as listed under CW
  - CTRL_BUBBLE = '0
- Sub-module id_ex_bypass (combinational):
  - Inputs: one specifier, the candidate value and the wb_* triple.
  - Output: the selected operand.
  - Instantiated twice for load and twice for snoop.
  - Compiled to a pass-through without ID_EX_BYPASS_EN.

## Test plan
- Reset, then accept one instruction: pc=0x40, rs1=3, ReadData1=7, in_valid=1, out_ready=1 → next cycle out_valid=1, ex_pc=0x40, ex_op1=7; bubble_count=1.
- Stall: out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, and payload and bubble_count are unchanged; on release the next instruction is accepted at the same edge.
- Load bypass (ID_EX_BYPASS_EN): id_rs2=5, ReadData2=1, wb_RegWrite=1, wb_rd=5, wb_data=0xAB → ex_op2=0xAB. With wb_rd=0 and id_rs2=0 → ex_op2=ReadData2.
- Hold snoop: FULL with ex_rs1=9, out_ready=0; write-back writes x9=0x1234 → next cycle ex_op1=0x1234 while out_valid stays 1.
- Flush while FULL and in_valid=1 → next cycle out_valid=0, ex_ctrl=0x00, and the incoming instruction never appears.
- Assert reset mid-stall with payload held → outputs go to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline types: widths, packed control word, ID/EX bundle.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int RAW  = 5;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       ALUSrc;
    logic       Branch;
    logic [1:0] ALUOp;
  } ctrl_t;

  localparam int    CW          = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    ctrl_t           ctrl;
  } id_ex_t;

endpackage

// File: rtl/id_ex_bypass.sv
// Write-back operand select; pass-through unless ID_EX_BYPASS_EN is defined.
module id_ex_bypass
  import riscv_pkg::*;
(
  input  logic [RAW-1:0]  rs,
  input  logic [XLEN-1:0] val,
  input  logic            wb_RegWrite,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op
);

`ifdef ID_EX_BYPASS_EN
  logic hit;

  // x0 is hardwired, so a write to it must never forward
  assign hit = wb_RegWrite && (wb_rd != '0) && (wb_rd == rs);
  assign op  = hit ? wb_data : val;
`else
  logic unused_wb;

  assign unused_wb = ^{wb_RegWrite, wb_rd, wb_data, rs};
  assign op        = val;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready, flush and write-back snoop.
// Forwarding enabled by defining ID_EX_BYPASS_EN.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  input  logic [RAW-1:0]  id_rd,
  input  logic [CW-1:0]   id_ctrl,
  input  logic            wb_RegWrite,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [RAW-1:0]  ex_rs1,
  output logic [RAW-1:0]  ex_rs2,
  output logic [RAW-1:0]  ex_rd,
  output logic [CW-1:0]   ex_ctrl,
  output logic [31:0]     bubble_count
);

  id_ex_t          q;
  logic            valid_q;
  logic            accept;
  logic [XLEN-1:0] ld_op1;
  logic [XLEN-1:0] ld_op2;
  logic [XLEN-1:0] sn_op1;
  logic [XLEN-1:0] sn_op2;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  id_ex_bypass u_ld1 (
    .rs          (id_rs1),
    .val         (ReadData1),
    .wb_RegWrite (wb_RegWrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op          (ld_op1)
  );

  id_ex_bypass u_ld2 (
    .rs          (id_rs2),
    .val         (ReadData2),
    .wb_RegWrite (wb_RegWrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op          (ld_op2)
  );

  id_ex_bypass u_sn1 (
    .rs          (q.rs1),
    .val         (q.op1),
    .wb_RegWrite (wb_RegWrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op          (sn_op1)
  );

  id_ex_bypass u_sn2 (
    .rs          (q.rs2),
    .val         (q.op2),
    .wb_RegWrite (wb_RegWrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op          (sn_op2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      q            <= '0;
      bubble_count <= '0;
    end else begin
      if (!valid_q)
        bubble_count <= bubble_count + 32'd1;
      if (flush) begin
        valid_q <= 1'b0;
        q.ctrl  <= CTRL_BUBBLE;
      end else if (accept) begin
        valid_q <= 1'b1;
        q.pc    <= id_pc;
        q.imm   <= id_imm;
        q.op1   <= ld_op1;
        q.op2   <= ld_op2;
        q.rs1   <= id_rs1;
        q.rs2   <= id_rs2;
        q.rd    <= id_rd;
        q.ctrl  <= ctrl_t'(id_ctrl);
      end else if (out_ready || !valid_q) begin
        valid_q <= 1'b0;
        q.ctrl  <= CTRL_BUBBLE;
      end else begin
        // stalled: keep held operands coherent with the register file
        q.op1 <= sn_op1;
        q.op2 <= sn_op2;
      end
    end
  end

  assign out_valid = valid_q;
  assign ex_pc     = q.pc;
  assign ex_imm    = q.imm;
  assign ex_op1    = q.op1;
  assign ex_op2    = q.op2;
  assign ex_rs1    = q.rs1;
  assign ex_rs2    = q.rs2;
  assign ex_rd     = q.rd;
  assign ex_ctrl   = q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (either ID_EX_BYPASS_EN setting).
module tb_id_ex_stage;

`ifdef ID_EX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [63:0] id_pc = '0;
  logic [63:0] id_imm = '0;
  logic [63:0] ReadData1 = '0;
  logic [63:0] ReadData2 = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic [4:0]  id_rd = '0;
  logic [7:0]  id_ctrl = '0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  logic [63:0] ex_op1;
  logic [63:0] ex_op2;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] bubble_count;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t m_hold = '0;
  exp_t e;
  logic m_v = 1'b0;
  logic [31:0] m_bub = '0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .id_pc        (id_pc),
    .id_imm       (id_imm),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_ctrl      (id_ctrl),
    .wb_RegWrite  (wb_RegWrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_ctrl      (ex_ctrl),
    .bubble_count (bubble_count)
  );

  function automatic exp_t obs();
    return {ex_pc, ex_imm, ex_op1, ex_op2,
            ex_rs1, ex_rs2, ex_rd, ex_ctrl};
  endfunction

  function automatic logic [63:0] byp(
    input logic [4:0]  rs,
    input logic [63:0] val
  );
    if (BYP && wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs)
      return wb_data;
    return val;
  endfunction

  task automatic drive(
    input logic [63:0] pc, imm, r1, r2,
    input logic [4:0]  s1, s2, d,
    input logic [7:0]  c
  );
    id_pc = pc; id_imm = imm;
    ReadData1 = r1; ReadData2 = r2;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_ctrl = c; in_valid = 1'b1;
  endtask

  // reference model advanced alongside each clock edge
  task automatic step();
    exp_t p;
    logic acc;
    acc = in_valid && (!m_v || out_ready) && !flush;
    if (!m_v) m_bub = m_bub + 32'd1;
    if (flush) begin
      m_v = 1'b0; m_hold.ctrl = '0;
    end else if (acc) begin
      p = {id_pc, id_imm, byp(id_rs1, ReadData1),
           byp(id_rs2, ReadData2), id_rs1, id_rs2,
           id_rd, id_ctrl};
      sb.push_back(p);
      m_hold = p;
      m_v = 1'b1;
    end else if (out_ready || !m_v) begin
      m_v = 1'b0; m_hold.ctrl = '0;
    end else begin
      m_hold.op1 = byp(m_hold.rs1, m_hold.op1);
      m_hold.op2 = byp(m_hold.rs2, m_hold.op2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (obs() !== exp_t'(0)) begin
      miscompares++;
      $display("FAIL reset_payload: got %h want 0", obs());
    end
    vectors++;
    if (bubble_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bubble: got %0d want 0", bubble_count);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_accept();
    out_ready = 1'b1;
    drive(64'h40, 64'h8, 64'd7, 64'd2, 5'd3, 5'd4, 5'd6, 8'hA2);
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_valid: got %b want 1", out_valid);
    end
    e = sb.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL accept_payload: got %h want %h", obs(), e);
    end
    vectors++;
    if (ex_pc !== 64'h40 || ex_op1 !== 64'd7) begin
      miscompares++;
      $display("FAIL accept_pc_op1: got %h/%h want 40/7", ex_pc, ex_op1);
    end
    vectors++;
    if (bubble_count !== 32'd1 || bubble_count !== m_bub) begin
      miscompares++;
      $display("FAIL accept_bubble: got %0d want 1", bubble_count);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
      miscompares++;
      $display("FAIL drain: got v=%b c=%h want 0/00", out_valid, ex_ctrl);
    end
  endtask

  task automatic test_stall();
    drive(64'h100, 64'h1, 64'h11, 64'h22, 5'd1, 5'd2, 5'd3, 8'h81);
    step();
    e = sb.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL stall_load: got %h want %h", obs(), e);
    end
    out_ready = 1'b0;
    drive(64'h104, 64'h2, 64'h33, 64'h44, 5'd7, 5'd8, 5'd10, 8'h42);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_in_ready: got %b want 0", in_ready);
      end
      step();
      vectors++;
      if (obs() !== m_hold || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold: got %h want %h", obs(), m_hold);
      end
      vectors++;
      if (bubble_count !== m_bub) begin
        miscompares++;
        $display("FAIL stall_bubble: got %0d want %0d", bubble_count, m_bub);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (obs() !== e || out_valid !== 1'b1 || ex_pc !== 64'h104) begin
      miscompares++;
      $display("FAIL release_next: got %h want %h", obs(), e);
    end
    step();
  endtask

  task automatic test_bypass();
    logic [63:0] want;
    wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 64'hAB;
    drive(64'h200, 64'h0, 64'h9, 64'h1, 5'd6, 5'd5, 5'd1, 8'h80);
    step();
    want = BYP ? 64'hAB : 64'h1;
    e = sb.pop_front();
    vectors++;
    if (obs() !== e || ex_op2 !== want) begin
      miscompares++;
      $display("FAIL bypass_rs2: got op2=%h want %h", ex_op2, want);
    end
    wb_rd = 5'd0; wb_data = 64'hDEAD;
    drive(64'h204, 64'h0, 64'h9, 64'h55, 5'd0, 5'd0, 5'd1, 8'h80);
    step();
    e = sb.pop_front();
    vectors++;
    if (obs() !== e || ex_op2 !== 64'h55) begin
      miscompares++;
      $display("FAIL bypass_x0: got op2=%h want 55", ex_op2);
    end
    wb_rd = 5'd12; wb_data = 64'hC0FFEE;
    drive(64'h208, 64'h0, 64'h3, 64'h4, 5'd12, 5'd13, 5'd1, 8'h80);
    step();
    want = BYP ? 64'hC0FFEE : 64'h3;
    e = sb.pop_front();
    vectors++;
    if (obs() !== e || ex_op1 !== want) begin
      miscompares++;
      $display("FAIL bypass_rs1: got op1=%h want %h", ex_op1, want);
    end
    in_valid = 1'b0; wb_RegWrite = 1'b0;
    step();
  endtask

  task automatic test_snoop();
    logic [63:0] want;
    drive(64'h300, 64'h0, 64'h11, 64'h22, 5'd9, 5'd0, 5'd2, 8'h90);
    step();
    e = sb.pop_front();
    in_valid = 1'b0;
    out_ready = 1'b0;
    wb_RegWrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h1234;
    step();
    want = BYP ? 64'h1234 : 64'h11;
    vectors++;
    if (obs() !== m_hold || ex_op1 !== want || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL snoop_rs1: got op1=%h v=%b want %h/1", ex_op1, out_valid, want);
    end
    wb_rd = 5'd0; wb_data = 64'hDEAD;
    step();
    vectors++;
    if (obs() !== m_hold || ex_op2 !== 64'h22) begin
      miscompares++;
      $display("FAIL snoop_x0: got op2=%h want 22", ex_op2);
    end
    wb_RegWrite = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    out_ready = 1'b1;
    wb_RegWrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h5555;
    drive(64'hDEAD0, 64'h0, 64'h1, 64'h2, 5'd1, 5'd2, 5'd3, 8'hFF);
    step();
    flush = 1'b0; in_valid = 1'b0; wb_RegWrite = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
      miscompares++;
      $display("FAIL flush: got v=%b c=%h want 0/00", out_valid, ex_ctrl);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL flush_sb: got %0d pending want 0", sb.size());
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || ex_pc === 64'hDEAD0 || bubble_count !== m_bub) begin
      miscompares++;
      $display("FAIL flush_drop: got v=%b pc=%h bub=%0d want 0/-/%0d",
               out_valid, ex_pc, bubble_count, m_bub);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb_RegWrite = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = {$urandom, $urandom};
      drive({$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), 8'($urandom));
      step();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_%0d: got %h want %h", i, obs(), e);
      end
    end
    in_valid = 1'b0; wb_RegWrite = 1'b0;
    step();
    vectors++;
    if (bubble_count !== m_bub) begin
      miscompares++;
      $display("FAIL b2b_bubble: got %0d want %0d", bubble_count, m_bub);
    end
  endtask

  task automatic test_async_reset();
    drive(64'h500, 64'h5, 64'h6, 64'h7, 5'd1, 5'd2, 5'd3, 8'hC3);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || ex_ctrl !== 8'hC3) begin
      miscompares++;
      $display("FAIL areset_pre: got v=%b c=%h want 1/c3", out_valid, ex_ctrl);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || obs() !== exp_t'(0) || bubble_count !== 32'd0) begin
      miscompares++;
      $display("FAIL areset: got v=%b p=%h bub=%0d want 0/0/0",
               out_valid, obs(), bubble_count);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_in_ready: got %b want 1", in_ready);
    end
    sb.delete();
    m_v = 1'b0; m_bub = '0; m_hold = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    vectors++;
    if (bubble_count !== m_bub || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_post: got bub=%0d want %0d", bubble_count, m_bub);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_stall();
    test_bypass();
    test_snoop();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
